// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage constants (ILEN, PC_RESET, NOP_INST) and fetch state encodings
package cpu_pkg;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] PC_RESET = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;
  typedef enum logic [1:0] {
    S_BUBBLE = 2'd0,
    S_LIVE   = 2'd1,
    S_HOLD   = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/if_skid_buf.sv
// if_skid_buf: stall skid buffer; ports clk/rst, flush, stall, rsp_valid, rdata in -> inst out
module if_skid_buf import cpu_pkg::*; #(
  parameter logic [ILEN-1:0] NOP = NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            stall,
  input  logic            rsp_valid,
  input  logic [ILEN-1:0] rdata,
  output logic [ILEN-1:0] inst
);
  logic            hold_valid;
  logic [ILEN-1:0] hold_inst;
  fetch_state_e    state;
  always_comb state = !rsp_valid ? S_BUBBLE : hold_valid ? S_HOLD : S_LIVE;
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_inst  <= NOP;
    end else if (flush) begin
      hold_valid <= 1'b0;
    end else if (stall) begin
      if (state == S_LIVE) begin
        hold_inst  <= rdata;
        hold_valid <= 1'b1;
      end
    end else begin
      hold_valid <= 1'b0;
    end
  end
  always_comb inst = state == S_HOLD ? hold_inst : state == S_LIVE ? rdata : NOP;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF stage; owns pc_f, drives imem (1-cycle read), delivers inst/pc/pc+4/valid/fetch_cnt to ID under stall_if and redirects
module if_fetch_unit import cpu_pkg::*; #(
  parameter logic [ILEN-1:0] PC_RESET_P = PC_RESET,
  parameter logic [ILEN-1:0] NOP_INST_P = NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_if,
  input  logic            redirect_valid,
  input  logic [ILEN-1:0] redirect_pc,
  output logic [ILEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [ILEN-1:0] inst_id,
  output logic [ILEN-1:0] pc_id,
  output logic [ILEN-1:0] pc_add4_id,
  output logic            valid_id,
  output logic [31:0]     fetch_cnt
);
  logic [ILEN-1:0] pc_f;
  logic [ILEN-1:0] rsp_pc;
  logic            rsp_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f      <= PC_RESET_P;
      rsp_pc    <= PC_RESET_P;
      rsp_valid <= 1'b0;
      fetch_cnt <= '0;
    end else if (redirect_valid) begin
      pc_f      <= {redirect_pc[ILEN-1:2], 2'b00};
      rsp_valid <= 1'b0;
    end else if (!stall_if) begin
      rsp_pc    <= pc_f;
      rsp_valid <= 1'b1;
      pc_f      <= pc_f + 32'd4;
      fetch_cnt <= fetch_cnt + {31'd0, rsp_valid};
    end
  end
  if_skid_buf #(.NOP(NOP_INST_P)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .stall     (stall_if),
    .rsp_valid (rsp_valid),
    .rdata     (imem_rdata),
    .inst      (inst_id)
  );
  assign imem_addr  = pc_f;
  assign valid_id   = rsp_valid;
  assign pc_id      = rsp_pc;
  assign pc_add4_id = rsp_pc + 32'd4;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed + scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_if = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr, imem_rdata, inst_id, pc_id, pc_add4_id, fetch_cnt;
  logic        valid_id;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mpc = 32'h0;
  logic [31:0] mcnt = 32'h0;

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall_if       (stall_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_id        (inst_id),
    .pc_id          (pc_id),
    .pc_add4_id     (pc_add4_id),
    .valid_id       (valid_id),
    .fetch_cnt      (fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'h0 ? 32'h0050_0093 : a == 32'h4 ? 32'h00A0_0113 : (a ^ 32'h5A00_0000) | 32'h3;
  endfunction

  always @(posedge clk) imem_rdata <= mem(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic s, input logic r, input logic [31:0] rp, input logic rs);
    logic [31:0] e;
    if (rs) begin
      exp_q.delete();
      mpc  = 32'h0;
      mcnt = 32'h0;
    end else if (r) begin
      exp_q.delete();
      mpc = {rp[31:2], 2'b00};
    end else if (!s) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", pc_id, e);
        chk("sb_inst", inst_id, mem(e));
        chk("sb_add4", pc_add4_id, e + 32'd4);
        mcnt++;
      end
      exp_q.push_back(mpc);
      mpc += 32'd4;
    end
    rst = rs;
    stall_if = s;
    redirect_valid = r;
    redirect_pc = rp;
    @(posedge clk);
    #1;
    chk("valid", {31'd0, valid_id}, {31'd0, exp_q.size() != 0});
    chk("fetch_cnt", fetch_cnt, mcnt);
    chk("imem_addr", imem_addr, mpc);
    if (exp_q.size() != 0) chk("pc_slot", pc_id, exp_q[0]);
  endtask

  initial begin
    tick(0, 0, 0, 1);
    chk("rst_valid", {31'd0, valid_id}, 32'd0);
    chk("rst_inst", inst_id, 32'h0000_0013);
    chk("rst_pc", pc_id, 32'h0);
    chk("rst_add4", pc_add4_id, 32'h4);
    tick(0, 0, 0, 0);
    chk("c2_pc", pc_id, 32'h0);
    chk("c2_inst", inst_id, 32'h0050_0093);
    tick(0, 0, 0, 0);
    chk("c3_pc", pc_id, 32'h4);
    chk("c3_inst", inst_id, 32'h00A0_0113);
    tick(0, 0, 0, 0);
    chk("c4_cnt", fetch_cnt, 32'd2);
    chk("c4_pc", pc_id, 32'h8);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 0);
      chk("stall_pc", pc_id, 32'h8);
      chk("stall_inst", inst_id, mem(32'h8));
      chk("stall_rdata", imem_rdata, mem(32'hC));
      chk("stall_cnt", fetch_cnt, 32'd2);
    end
    tick(0, 0, 0, 0);
    chk("rel_pc", pc_id, 32'hC);
    chk("rel_inst", inst_id, mem(32'hC));
    chk("rel_cnt", fetch_cnt, 32'd3);
    tick(0, 0, 0, 0);
    chk("pre_redir_pc", pc_id, 32'h10);
    tick(0, 1, 32'h40, 0);
    chk("redir_bubble", {31'd0, valid_id}, 32'd0);
    tick(0, 0, 0, 0);
    chk("redir_valid", {31'd0, valid_id}, 32'd1);
    chk("redir_pc", pc_id, 32'h40);
    chk("redir_inst", inst_id, mem(32'h40));
    chk("redir_add4", pc_add4_id, 32'h44);
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("hold_pc", pc_id, 32'h44);
    tick(1, 1, 32'h40, 0);
    chk("sr_bubble", {31'd0, valid_id}, 32'd0);
    chk("sr_inst", inst_id, 32'h0000_0013);
    tick(0, 0, 0, 0);
    chk("sr_pc", pc_id, 32'h40);
    chk("sr_inst2", inst_id, mem(32'h40));
    tick(0, 1, 32'h43, 0);
    chk("align_addr", imem_addr, 32'h40);
    tick(0, 1, 32'hFFFF_FFFC, 0);
    chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    tick(0, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_add4", pc_add4_id, 32'h0);
    chk("wrap_pc", pc_id, 32'hFFFF_FFFC);
    tick(0, 0, 0, 0);
    chk("wrap_inst", inst_id, mem(32'h0));
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 1);
    chk("rh_valid", {31'd0, valid_id}, 32'd0);
    chk("rh_cnt", fetch_cnt, 32'd0);
    chk("rh_addr", imem_addr, 32'h0);
    for (int i = 0; i < 60; i++) begin
      logic s, r;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 7) == 0);
      tick(s, r, $urandom, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
